// File: rtl/fracmod_pkg.sv
// Shared definitions for the fraction-mod-q inverse datapath.
//   FM_W        operand/result width of the divider
//   FM_Q        modulus q of the inverse datapath
//   div_state_t divider controller states
package fracmod_pkg;

  localparam int FM_W = 13;
  localparam int FM_Q = 4591;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } div_state_t;

endpackage

// File: rtl/fracmod_div_if.sv
// Handshake/result bundle between the Euclid controller and the divider.
//   master (controller): drives start, dividend, divisor; reads busy, done,
//                        qdiv, rdiv, dbz
//   slave  (divider)   : the mirror image
interface fracmod_div_if
  import fracmod_pkg::*;
#(
  parameter int W = FM_W
);

  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] qdiv;
  logic [W-1:0] rdiv;
  logic         dbz;

  modport master (
    output start, dividend, divisor,
    input  busy, done, qdiv, rdiv, dbz
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, qdiv, rdiv, dbz
  );

endinterface

// File: rtl/fracmod_div_step.sv
// One restoring-division iteration (purely combinational).
//   rem      current partial remainder (W+1 bits)
//   bit_in   dividend bit shifted into the remainder
//   dsr      divisor
//   rem_next partial remainder after the trial subtraction
//   q_bit    quotient bit produced by this iteration
module fracmod_div_step
  import fracmod_pkg::*;
#(
  parameter int W = FM_W
) (
  input  logic [W:0]   rem,
  input  logic         bit_in,
  input  logic [W-1:0] dsr,
  output logic [W:0]   rem_next,
  output logic         q_bit
);

  logic [W+1:0] t;
  logic [W+1:0] d;
  logic [W:0]   diff;

  // The remainder stays below dsr, so its top bit is always zero; the
  // shifted value is nevertheless compared at full width so nothing is lost.
  always_comb begin
    t        = {rem, bit_in};
    d        = {2'b00, dsr};
    diff     = t[W:0] - d[W:0];
    q_bit    = (t >= d);
    rem_next = q_bit ? diff : t[W:0];
  end

endmodule

// File: rtl/fracmod_div.sv
// Sequential unsigned radix-2 restoring divider, one quotient bit per clock.
// Supplies quotient/remainder to the extended-Euclid controller.
//   clk    rising-edge clock
//   rst_n  synchronous reset, active-low
//   bus    fracmod_div_if slave: start/dividend/divisor in,
//          busy/done/qdiv/rdiv/dbz out
// A zero divisor skips the iterations and reports all-ones quotient,
// remainder equal to the dividend and dbz set. Results hold until the next
// completion.
module fracmod_div
  import fracmod_pkg::*;
#(
  parameter int W = FM_W
) (
  input  logic          clk,
  input  logic          rst_n,
  fracmod_div_if.slave  bus
);

  localparam int              CNT_W    = $clog2(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W - 1);

  div_state_t       state;
  div_state_t       state_next;
  logic [W:0]       rem;
  logic [W-1:0]     quo;
  logic [W-1:0]     dsr;
  logic [CNT_W-1:0] cnt;

  logic             busy_q;
  logic             done_q;
  logic             dbz_q;
  logic [W-1:0]     qdiv_q;
  logic [W-1:0]     rdiv_q;

  logic [W:0]       rem_next;
  logic             q_bit;
  logic [W-1:0]     quo_next;

  fracmod_div_step #(
    .W (W)
  ) u_step (
    .rem      (rem),
    .bit_in   (quo[W-1]),
    .dsr      (dsr),
    .rem_next (rem_next),
    .q_bit    (q_bit)
  );

  assign quo_next = {quo[W-2:0], q_bit};

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_next = (bus.divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt == '0) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they carry no
  // combinational path from the inputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      qdiv_q <= '0;
      rdiv_q <= '0;
      rem    <= '0;
      quo    <= '0;
      dsr    <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != IDLE);
      done_q <= (state_next == DONE);
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.divisor != '0) begin
              rem   <= '0;
              quo   <= bus.dividend;
              dsr   <= bus.divisor;
              cnt   <= CNT_LAST;
              dbz_q <= 1'b0;
            end else begin
              qdiv_q <= '1;
              rdiv_q <= bus.dividend;
              dbz_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          rem <= rem_next;
          quo <= quo_next;
          if (cnt == '0) begin
            qdiv_q <= quo_next;
            rdiv_q <= rem_next[W-1:0];
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.dbz  = dbz_q;
  assign bus.qdiv = qdiv_q;
  assign bus.rdiv = rdiv_q;

endmodule

// File: tb/tb_fracmod_div.sv
// Self-checking bench for fracmod_div: directed vector table, hand-written
// reset / back-to-back sequences and a randomized identity scoreboard.
module tb_fracmod_div;
  import fracmod_pkg::*;

  localparam int W = FM_W;

  logic clk;
  logic rst_n;

  fracmod_div_if #(.W(W)) bus ();

  fracmod_div #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cmp_cnt  = 0;
  int fail_cnt = 0;

  // lat = index of the edge after the accepting edge (edge 0) at whose
  // following low phase done is first seen: W for a real divide, 0 for /0.
  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dsr;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input int act, input int req);
    cmp_cnt++;
    if (act != req) begin
      fail_cnt++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic do_op(input logic [W-1:0] dvd, input logic [W-1:0] dsr,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic z, output int lat,
                       output logic busy_rise, output logic pulse_ok,
                       output logic idle_ok);
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = dvd;
    bus.divisor  = dsr;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = 13'h1abc;
    bus.divisor  = 13'h0f0f;
    busy_rise    = bus.busy;
    lat          = 0;
    while (!bus.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    q = bus.qdiv;
    r = bus.rdiv;
    z = bus.dbz;
    @(negedge clk);
    pulse_ok = !bus.done;
    idle_ok  = !bus.busy;
  endtask

  logic [W-1:0] q, r, dv, ds;
  logic         z, br, po, io;
  int           lat;
  int           seen;
  int           last_done;
  int           gap_ok;

  initial begin
    vecs[0] = '{13'd4591, 13'd1000, 13'd4,    13'd591,  1'b0, W};
    vecs[1] = '{13'd8191, 13'd1,    13'd8191, 13'd0,    1'b0, W};
    vecs[2] = '{13'd5,    13'd7,    13'd0,    13'd5,    1'b0, W};
    vecs[3] = '{13'd1000, 13'd0,    13'd8191, 13'd1000, 1'b1, 0};
    vecs[4] = '{13'd12,   13'd4,    13'd3,    13'd0,    1'b0, W};
    vecs[5] = '{13'd0,    13'd5,    13'd0,    13'd0,    1'b0, W};
    vecs[6] = '{13'd8191, 13'd8191, 13'd1,    13'd0,    1'b0, W};
    vecs[7] = '{13'd4590, 13'd4591, 13'd0,    13'd4590, 1'b0, W};
    vecs[8] = '{13'd0,    13'd0,    13'd8191, 13'd0,    1'b1, 0};
    vecs[9] = '{13'd8191, 13'd2,    13'd4095, 13'd1,    1'b0, W};

    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    chk("reset_qdiv", bus.qdiv, 0);
    chk("reset_rdiv", bus.rdiv, 0);
    chk("reset_dbz",  bus.dbz,  0);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].dvd, vecs[i].dsr, q, r, z, lat, br, po, io);
      chk($sformatf("vec%0d_qdiv", i), q, vecs[i].q);
      chk($sformatf("vec%0d_rdiv", i), r, vecs[i].r);
      chk($sformatf("vec%0d_dbz", i), z, vecs[i].z);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
      chk($sformatf("vec%0d_busy_rise", i), br, 1);
      chk($sformatf("vec%0d_one_pulse", i), po, 1);
      chk($sformatf("vec%0d_idle_after", i), io, 1);
      repeat (3) @(negedge clk);
      chk($sformatf("vec%0d_hold_qdiv", i), bus.qdiv, vecs[i].q);
      chk($sformatf("vec%0d_hold_rdiv", i), bus.rdiv, vecs[i].r);
    end

    // Reset in the middle of RUN discards the operation.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 13'd4591;
    bus.divisor  = 13'd1000;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrun_busy_before", bus.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrun_rst_busy", bus.busy, 0);
    chk("midrun_rst_done", bus.done, 0);
    chk("midrun_rst_qdiv", bus.qdiv, 0);
    chk("midrun_rst_rdiv", bus.rdiv, 0);
    chk("midrun_rst_dbz",  bus.dbz,  0);
    rst_n = 1'b1;
    seen  = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done || bus.busy) seen++;
    end
    chk("midrun_no_done", seen, 0);
    do_op(13'd4591, 13'd1000, q, r, z, lat, br, po, io);
    chk("after_rst_qdiv", q, 4);
    chk("after_rst_rdiv", r, 591);
    chk("after_rst_lat", lat, W);

    // start held high: accepts on edges 0, 15, 30; done after edges 13, 28.
    @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 13'd4591;
    bus.divisor  = 13'd13;
    @(posedge clk);
    seen      = 0;
    last_done = -1;
    gap_ok    = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done) begin
        seen++;
        chk($sformatf("held_qdiv_%0d", i), bus.qdiv, 353);
        chk($sformatf("held_rdiv_%0d", i), bus.rdiv, 2);
        if (last_done < 0) chk("held_first_done", i, W);
        else               chk("held_spacing", i - last_done, W + 2);
        last_done = i;
      end
      if ((i + 1 >= 3 && i + 1 <= 10) || (i + 1 >= 18 && i + 1 <= 25)) begin
        bus.dividend = 13'd77;
        bus.divisor  = 13'd0;
      end else begin
        bus.dividend = 13'd4591;
        bus.divisor  = 13'd13;
      end
    end
    chk("held_done_count", seen, 2);
    bus.start = 1'b0;
    seen = 0;
    while (bus.busy && seen < 40) begin
      @(negedge clk);
      seen++;
    end
    chk("held_drain", bus.busy, 0);

    // Randomized identity scoreboard.
    for (int n = 0; n < 2000; n++) begin
      dv = 13'($urandom_range(0, 8191));
      ds = ($urandom_range(0, 15) == 0) ? 13'd0 : 13'($urandom_range(0, 8191));
      do_op(dv, ds, q, r, z, lat, br, po, io);
      if (ds == 0) begin
        chk("rand_dbz_q", q, 8191);
        chk("rand_dbz_r", r, dv);
        chk("rand_dbz_flag", z, 1);
        chk("rand_dbz_lat", lat, 0);
      end else begin
        chk("rand_identity", int'(q) * int'(ds) + int'(r), dv);
        chk("rand_r_lt_d", int'(r < ds), 1);
        chk("rand_dbz_flag", z, 0);
        chk("rand_lat", lat, W);
      end
      chk("rand_one_pulse", po, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, fail_cnt);
    $finish;
  end

endmodule
